alu_ctrl_muldiv: RTL
====================

# alu_ctrl_muldiv

Parametrised successor to the single-cycle ALU control decoder. Decodes ALUop plus the full 6-bit funct into a 4-bit ALU control code, and adds a multi-cycle multiply/divide sequencer with HI/LO registers, a busy/stall handshake and mfhi/mflo/mthi/mtlo support. Sits between the main control unit and the ALU/register-file write-back mux in the EX stage.

## Interface
- WIDTH, 32, operand and HI/LO width (≥4, power of two)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- ALUop  in  2  from main control
- funct  in  6  instruction funct field
- valid  in  1  instruction present this cycle
- rs_val  in  WIDTH  operand A (dividend/multiplicand, mthi/mtlo source)
- rt_val  in  WIDTH  operand B (divisor/multiplier)
- ALUcontrol  out  4  combinational ALU opcode
- illegal  out  1  combinational; ALUop=10 with unrecognised funct
- stall  out  1  combinational; hold the instruction this cycle
- busy  out  1  sequencer active
- done  out  1  one-cycle pulse when HI/LO updated by mult/div
- hi, lo  out  WIDTH each  registered HI/LO
- mf_data  out  WIDTH  combinational: hi for mfhi, lo for mflo, else 0

## Operation
- ALUop 00 → 0010; 01 → 0110; 11 → 0000 (andi-class).
- ALUop 10, full funct: 100000 add → 0010; 100010 sub → 0110; 100100 and → 0000; 100101 or → 0001; 101010 slt → 0111; 100111 nor → 1100.
- Mult/div/mf/mt functs (011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo) → ALUcontrol 0010, illegal=0.
- Any other funct with ALUop 10 → ALUcontrol 0010, illegal=1. No latch behaviour: every input combination drives a defined output.
- Accept: valid & ALUop=10 & md funct & !busy, sampled at clk edge. Captures operands, clears counter, enters RUN.
- Signed ops (mult, div): operate on magnitudes, record result signs; quotient sign = sign(a)^sign(b), remainder sign = sign(a), product sign = sign(a)^sign(b).
- Multiply: shift-add, one bit per cycle, 2·WIDTH-bit product; hi = upper, lo = lower half.
- Divide: restoring, one bit per cycle; lo = quotient, hi = remainder.
- Divide by zero: lo = all ones, hi = rs_val as captured; same latency, no error flag.
- mthi/mtlo when !busy: hi/lo ← rs_val at that edge.
- stall = valid & busy & (any md, mf or mt funct with ALUop=10). Non-md instructions never stall.
- States: IDLE → RUN on accept; RUN → FIN when counter = WIDTH-1; FIN → IDLE unconditionally (HI/LO written, done=1). A new accept is allowed in IDLE only, so it may occur on the edge that ends FIN only if busy=0 then (it is not).

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Combinational outputs follow inputs immediately.
- Accept at edge E0. busy=1 from after E0. Iterations at E1…E_WIDTH. FIN at E_WIDTH+1: hi/lo updated, done=1 for that cycle, busy=0 after E_WIDTH+1. busy is high for WIDTH+1 cycles.
- mf read on the cycle busy falls returns new hi/lo (registered values already valid).
- mthi/mtlo latency: one edge. Ignored while busy because stall is asserted.
- Reset mid-operation: aborts immediately, hi/lo cleared, no done pulse.
- Counter width clog2(WIDTH); no wrap beyond WIDTH-1.

## Test plan
- ALUop=10, funct 100111 → ALUcontrol 1100, illegal 0. funct 111111 → ALUcontrol 0010, illegal 1. ALUop 01 → 0110.
- multu rs=7, rt=6 → busy exactly 33 cycles, done pulse once, hi=0, lo=42.
- mult rs=-5 (0xFFFFFFFB), rt=3 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div rs=-7, rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu rs=9, rt=0 → lo=0xFFFFFFFF, hi=9.
- mflo presented while busy → stall=1 each cycle until busy falls. Then mf_data = new lo. An add during busy → stall=0.
- Assert reset 10 cycles into a div → busy=0, hi=lo=0 asynchronously, no done. mtlo 0x1234 afterwards → lo=0x1234 next edge.

Source files
------------

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decoder with a one-bit-per-cycle multiply/divide sequencer.
// It also owns the HI/LO registers and handles mfhi/mflo/mthi/mtlo.
module alu_ctrl_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       ALUcontrol,
    output logic             illegal,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic rtype, is_md, is_mf, is_mt, accept, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_next, prod;
    logic [WIDTH:0]     msum, rshift, rdiff;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign rtype = (ALUop == 2'b10);
    assign is_md = (funct[5:2] == 4'b0110);
    assign is_mf = (funct == 6'b010000) || (funct == 6'b010010);
    assign is_mt = (funct == 6'b010001) || (funct == 6'b010011);

    always_comb begin
        ALUcontrol = 4'b0010;
        illegal    = 1'b0;
        case (ALUop)
            2'b00: ALUcontrol = 4'b0010;
            2'b01: ALUcontrol = 4'b0110;
            2'b11: ALUcontrol = 4'b0000;
            default: begin
                case (funct)
                    6'b100000: ALUcontrol = 4'b0010;
                    6'b100010: ALUcontrol = 4'b0110;
                    6'b100100: ALUcontrol = 4'b0000;
                    6'b100101: ALUcontrol = 4'b0001;
                    6'b101010: ALUcontrol = 4'b0111;
                    6'b100111: ALUcontrol = 4'b1100;
                    default: begin
                        ALUcontrol = 4'b0010;
                        illegal    = !(is_md || is_mf || is_mt);
                    end
                endcase
            end
        endcase
    end

    // Handshake: an instruction is taken only when valid is high and stall is low;
    // while stall is high the upstream stage must hold the same instruction.
    assign busy      = (state != S_IDLE);
    assign stall     = valid && busy && rtype && (is_md || is_mf || is_mt);
    assign accept    = valid && rtype && is_md && !busy;
    assign dbg_state = state;

    always_comb begin
        mf_data = '0;
        if (rtype && funct == 6'b010000) mf_data = hi;
        else if (rtype && funct == 6'b010010) mf_data = lo;
    end

    // mult and div have funct[0]=0; the unsigned variants have it set.
    assign is_signed = !funct[0];
    assign a_neg     = is_signed && rs_val[WIDTH-1];
    assign b_neg     = is_signed && rt_val[WIDTH-1];
    assign a_mag     = a_neg ? (~rs_val + 1'b1) : rs_val;
    assign b_mag     = b_neg ? (~rt_val + 1'b1) : rt_val;

    // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, quotient}.
    always_comb begin
        msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rshift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rdiff  = rshift - {1'b0, opnd};
        if (!op_div)
            acc_next = {msum, acc[WIDTH-1:1]};
        else if (!rdiff[WIDTH])
            acc_next = {rdiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_next = {rshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    assign prod  = neg_q ? (~acc + 1'b1) : acc;
    assign q_fix = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    assign r_fix = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        op_div   <= funct[1];
                        opnd     <= funct[1] ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (funct[1] ? a_mag : b_mag)};
                        a_raw    <= rs_val;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (rt_val == '0);
                    end else if (valid && rtype && is_mt) begin
                        if (funct[1]) lo <= rs_val;
                        else          hi <= rs_val;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    if (cnt == CW'(WIDTH - 1)) state <= S_FIN;
                    else                       cnt   <= cnt + 1'b1;
                end
                S_FIN: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    done  <= 1'b1;
                    if (!op_div) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
